// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep controller feeding a DDS: loads tuning/phase words, steps the tuning word
// with a programmable dwell, optional restart. Define DDS_SWEEP_BIDIR_EN for triangle sweeps.
module dds_sweep_ctrl #(
    parameter int unsigned FrequencyBitWidth = 32,
    parameter int unsigned PhaseBitWidth     = 10,
    parameter int unsigned DwellBitWidth     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         cont,
    input  logic [FrequencyBitWidth-1:0] f_start,
    input  logic [FrequencyBitWidth-1:0] f_stop,
    input  logic [FrequencyBitWidth-1:0] f_step,
    input  logic [DwellBitWidth-1:0]     dwell,
    input  logic [PhaseBitWidth-1:0]     phase_in,
    output logic [FrequencyBitWidth-1:0] Freword,
    output logic [PhaseBitWidth-1:0]     Phaword,
    output logic                         busy,
    output logic                         step_strobe,
    output logic                         done
);

    localparam int unsigned FW = FrequencyBitWidth;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        LAST,
`ifdef DDS_SWEEP_BIDIR_EN
        DOWN,
`endif
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [FW-1:0]           freword_d;
    logic [PhaseBitWidth-1:0] phaword_d;
    logic [DwellBitWidth-1:0] cnt_q, cnt_d;
    logic                    strobe_d;
    logic [FW-1:0]           start_q, start_d, stop_q, stop_d, step_q, step_d;
    logic [DwellBitWidth-1:0] dwell_q, dwell_d;
    logic                    cont_q, cont_d;
    logic [FW:0]             sum;
    logic                    point_end;
`ifdef DDS_SWEEP_BIDIR_EN
    logic [FW:0]             floor_lim;
    logic [FW-1:0]           diff;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            Freword     <= '0;
            Phaword     <= '0;
            cnt_q       <= '0;
            step_strobe <= 1'b0;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            cont_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            Freword     <= freword_d;
            Phaword     <= phaword_d;
            cnt_q       <= cnt_d;
            step_strobe <= strobe_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            step_q      <= step_d;
            dwell_q     <= dwell_d;
            cont_q      <= cont_d;
        end
    end

    // Wide sum so a step past the top of the range saturates at f_stop instead of wrapping
    assign sum       = {1'b0, Freword} + {1'b0, step_q};
    assign point_end = (cnt_q == dwell_q);
`ifdef DDS_SWEEP_BIDIR_EN
    assign floor_lim = {1'b0, start_q} + {1'b0, step_q};
    assign diff      = Freword - step_q;
`endif

    always_comb begin
        state_d   = state_q;
        freword_d = Freword;
        phaword_d = Phaword;
        cnt_d     = cnt_q;
        strobe_d  = 1'b0;
        start_d   = start_q;
        stop_d    = stop_q;
        step_d    = step_q;
        dwell_d   = dwell_q;
        cont_d    = cont_q;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        start_d   = f_start;
                        stop_d    = f_stop;
                        step_d    = f_step;
                        dwell_d   = dwell;
                        cont_d    = cont;
                        freword_d = f_start;
                        phaword_d = phase_in;
                        cnt_d     = '0;
                        strobe_d  = 1'b1;
                        state_d   = (f_start >= f_stop) ? LAST : RUN;
                    end
                end
                RUN: begin
                    if (point_end) begin
                        cnt_d    = '0;
                        strobe_d = 1'b1;
                        if (sum >= {1'b0, stop_q}) begin
                            freword_d = stop_q;
                            state_d   = LAST;
                        end else begin
                            freword_d = sum[FW-1:0];
                        end
                    end else begin
                        cnt_d = cnt_q + DwellBitWidth'(1);
                    end
                end
`ifdef DDS_SWEEP_BIDIR_EN
                // The LAST exit already takes the first downward step, so the peak is held
                // dwell+1 cycles like every other point.
                LAST, DOWN: begin
                    if (point_end) begin
                        cnt_d    = '0;
                        strobe_d = 1'b1;
                        if ({1'b0, Freword} <= floor_lim) begin
                            freword_d = start_q;
                            state_d   = DONE;
                        end else begin
                            freword_d = diff;
                            state_d   = DOWN;
                        end
                    end else begin
                        cnt_d = cnt_q + DwellBitWidth'(1);
                    end
                end
`else
                LAST: begin
                    if (point_end) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + DwellBitWidth'(1);
                    end
                end
`endif
                DONE: begin
                    cnt_d = '0;
                    if (cont_q) begin
                        freword_d = start_q;
                        strobe_d  = 1'b1;
                        state_d   = (start_q >= stop_q) ? LAST : RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef DDS_SWEEP_BIDIR_EN
    assign busy = (state_q == RUN) || (state_q == LAST) || (state_q == DOWN);
`else
    assign busy = (state_q == RUN) || (state_q == LAST);
`endif
    assign done = (state_q == DONE);

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter FrequencyBitWidth, default 32, width of the frequency tuning word and sweep operands.
REQ-002 SHALL have parameter PhaseBitWidth, default 10, width of the phase offset word.
REQ-003 SHALL have parameter DwellBitWidth, default 16, width of the dwell counter.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  level, sampled in IDLE only; begins a sweep.
REQ-007 abort  input  1  level; stops the sweep from any state.
REQ-008 cont  input  1  1 = restart from f_start after DONE, 0 = single sweep.
REQ-009 f_start, f_stop, f_step  input  FrequencyBitWidth each  sweep bounds and increment (unsigned).
REQ-010 dwell  input  DwellBitWidth  extra hold cycles per frequency point.
REQ-011 phase_in  input  PhaseBitWidth  phase offset for the sweep.
REQ-012 Freword  output  FrequencyBitWidth  registered tuning word to the DDS.
REQ-013 Phaword  output  PhaseBitWidth  registered phase word to the DDS.
REQ-014 busy  output  1  high in RUN, LAST, DOWN.
REQ-015 step_strobe  output  1  one-cycle pulse on each Freword update, including the first load.
REQ-016 done  output  1  one-cycle pulse in DONE.

Function
REQ-017 SHALL implement states IDLE, RUN, LAST, DONE (plus DOWN, see REQ-029).
REQ-018 On the edge sampling start=1 in IDLE: latch f_start, f_stop, f_step, dwell, phase_in, cont; Freword<=f_start; Phaword<=phase_in; dwell counter<=0; step_strobe<=1; go to RUN, or to LAST if f_start>=f_stop.
REQ-019 Inputs other than abort SHALL be ignored outside IDLE; latched values govern the sweep.
REQ-020 Dwell counter increments each cycle in RUN/LAST/DOWN; each frequency point is held exactly dwell+1 cycles.
REQ-021 In RUN, when counter==dwell: sum = Freword+f_step computed at FrequencyBitWidth+1 bits; if sum>=f_stop, Freword<=f_stop and go to LAST, else Freword<=sum and stay in RUN; counter<=0; step_strobe<=1.
REQ-022 f_step==0 SHALL hold f_start indefinitely in RUN, with step_strobe pulsing every dwell+1 cycles, until abort.
REQ-023 In LAST, when counter==dwell: go to DONE (macro off) or DOWN (macro on).
REQ-024 DONE SHALL last one cycle with done=1; if latched cont=1, Freword<=f_start, step_strobe<=1, and go to RUN (or LAST per REQ-018 compare); else go to IDLE.
REQ-025 Freword and Phaword SHALL hold their last value in IDLE.
REQ-026 abort=1 SHALL force IDLE on the next edge from any state, with no done pulse and Freword/Phaword held; abort has priority over start and over any step.

Reset
REQ-027 rst_n=0 SHALL asynchronously set state=IDLE, Freword=0, Phaword=0, dwell counter=0, busy=0, step_strobe=0, done=0, and clear all latched operands.
REQ-028 Reset mid-sweep SHALL discard the sweep; after release the block waits in IDLE for start.

Configuration
REQ-029 With macro DDS_SWEEP_BIDIR_EN defined: LAST exits to DOWN; in DOWN, each time counter==dwell, diff = Freword-f_step; if Freword<=f_start+f_step (evaluated at FrequencyBitWidth+1 bits), Freword<=f_start and go to DONE, else Freword<=diff; step_strobe<=1 on every update; this yields a triangle sweep.
REQ-030 Without DDS_SWEEP_BIDIR_EN: no DOWN state exists and the sweep is sawtooth only.

Verification
REQ-031 f_start=100, f_stop=130, f_step=10, dwell=2, cont=0, start pulse -> Freword 100,110,120,130, each held 3 cycles, 4 step_strobes, done one cycle after 130 ends, busy low after.
REQ-032 f_start=0xFFFFFFF0, f_stop=0xFFFFFFFF, f_step=0x20 -> no wrap; Freword 0xFFFFFFF0 then 0xFFFFFFFF, then done.
REQ-033 Same as REQ-031 with cont=1 -> after done, Freword returns to 100 with step_strobe; abort asserted at Freword=120 -> IDLE next edge, Freword stays 120, no done.
REQ-034 start and abort both high in IDLE -> remains IDLE, busy=0; f_start=200, f_stop=150 -> Freword=200 for dwell+1 cycles, then done.
REQ-035 With DDS_SWEEP_BIDIR_EN, f_start=100, f_stop=130, f_step=10, dwell=0 -> Freword 100,110,120,130,120,110,100, one cycle each, then done; rst_n low mid-sweep -> all outputs 0 immediately.
